// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types plus the RAM responder constants and address check.
package cpu_types_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned RAM_LAT_DEFAULT = 2;
  localparam int unsigned RAM_DEPTH_BITS  = 8;
  localparam int unsigned RAM_CNT_W       = 4;

  typedef logic [WORD_W-1:0] word_t;

  // Per-cycle RAM status reported back to the memory controller.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Request identity used to detect a new transaction (address or op change).
  typedef struct packed {
    logic  ren;
    logic  wen;
    word_t addr;
  } ram_req_t;

  // True when the byte address is word aligned and inside a 2**depth_bits word array.
  function automatic logic ram_addr_ok(word_t a, int depth_bits);
    word_t hi;
    hi = a >> (depth_bits + 2);
    return (a[1:0] == 2'b00) && (hi == '0);
  endfunction

endpackage

// File: rtl/ram_responder_if.sv
// RAM-side handshake between the memory controller (master) and the RAM (slave).
interface ram_responder_if;
  import cpu_types_pkg::*;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

// File: rtl/ram_responder_array.sv
// Word-wide storage with two write ports (port a beats port b on the same index)
// and two asynchronous read ports. Contents are deliberately not reset.
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH_BITS = RAM_DEPTH_BITS
) (
  input  logic                  CLK,
  input  logic                  a_wen,
  input  logic [DEPTH_BITS-1:0] a_idx,
  input  word_t                 a_wdata,
  input  logic                  b_wen,
  input  logic [DEPTH_BITS-1:0] b_idx,
  input  word_t                 b_wdata,
  input  logic [DEPTH_BITS-1:0] ra_idx,
  output word_t                 ra_data,
  input  logic [DEPTH_BITS-1:0] rb_idx,
  output word_t                 rb_data
);

  localparam int unsigned DEPTH = 2 ** DEPTH_BITS;

  word_t mem [DEPTH];

  logic b_blocked;

  // Port b is suppressed only when port a writes the same word this edge.
  always_comb begin
    b_blocked = a_wen && (a_idx == b_idx);
  end

  // Commit both write ports; different indices land together.
  always_ff @(posedge CLK) begin
    if (b_wen && !b_blocked) begin
      mem[b_idx] <= b_wdata;
    end
    if (a_wen) begin
      mem[a_idx] <= a_wdata;
    end
  end

  assign ra_data = mem[ra_idx];
  assign rb_data = mem[rb_idx];

endmodule

// File: rtl/ram_responder.sv
// RAM responder: programmable-latency word RAM answering the controller's
// REN/WEN handshake with FREE/BUSY/ACCESS/ERROR, plus a debug backdoor port.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT        = RAM_LAT_DEFAULT,
  parameter int unsigned DEPTH_BITS = RAM_DEPTH_BITS
) (
  input  logic           CLK,
  input  logic           nRST,
  ram_responder_if.slave ram,
  input  logic           dbgWEN,
  input  word_t          dbgaddr,
  input  word_t          dbgstore,
  output word_t          dbgload
);

  localparam logic [RAM_CNT_W-1:0] LAT_CNT = RAM_CNT_W'(LAT);

  ram_req_t               req_cur;
  ram_req_t               req_lat;
  logic [RAM_CNT_W-1:0]   cnt;
  logic [RAM_CNT_W-1:0]   cnt_eff;
  logic                   busy;
  logic                   req_any;
  logic                   req_err;
  logic                   new_txn;
  logic                   access;
  ramstate_t              state_c;
  word_t                  load_c;
  word_t                  rd_data;
  logic                   wr_en;
  logic [DEPTH_BITS-1:0]  ram_idx;
  logic [DEPTH_BITS-1:0]  dbg_idx;
  logic                   unused_dbgaddr;

  assign ram_idx        = ram.ramaddr[DEPTH_BITS+1:2];
  assign dbg_idx        = dbgaddr[DEPTH_BITS+1:2];
  assign unused_dbgaddr = ^{dbgaddr[WORD_W-1:DEPTH_BITS+2], dbgaddr[1:0]};

  // Classify the current cycle; a held reset reads as an idle RAM.
  always_comb begin
    req_cur = '{ren: ram.ramREN, wen: ram.ramWEN, addr: ram.ramaddr};
    req_any = nRST && (ram.ramREN || ram.ramWEN);
    req_err = nRST && ((ram.ramREN && ram.ramWEN) ||
                       !ram_addr_ok(ram.ramaddr, int'(DEPTH_BITS)));
    new_txn = !busy || (req_cur != req_lat);
    cnt_eff = new_txn ? '0 : cnt;
    access  = req_any && !req_err && (cnt_eff == LAT_CNT);
    wr_en   = access && ram.ramWEN;

    state_c = BUSY;
    load_c  = '0;
    if (req_err) begin
      state_c = ERROR;
    end else if (!req_any) begin
      state_c = FREE;
    end else if (access) begin
      state_c = ACCESS;
      if (ram.ramREN) begin
        load_c = rd_data;
      end
    end
  end

  assign ram.ramstate = state_c;
  assign ram.ramload  = load_c;

  // Latency counter and latched request; any idle, error or completed access
  // clears the busy flag so the next request cycle starts a fresh transaction.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt     <= '0;
      busy    <= 1'b0;
      req_lat <= '0;
    end else if (req_err || !req_any || access) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      busy    <= 1'b1;
      req_lat <= req_cur;
      cnt     <= (cnt_eff == LAT_CNT) ? LAT_CNT : cnt_eff + RAM_CNT_W'(1);
    end
  end

  // Storage: controller writes take priority over the debug backdoor.
  ram_array #(
    .DEPTH_BITS (DEPTH_BITS)
  ) u_ram_array (
    .CLK     (CLK),
    .a_wen   (wr_en),
    .a_idx   (ram_idx),
    .a_wdata (ram.ramstore),
    .b_wen   (dbgWEN),
    .b_idx   (dbg_idx),
    .b_wdata (dbgstore),
    .ra_idx  (ram_idx),
    .ra_data (rd_data),
    .rb_idx  (dbg_idx),
    .rb_data (dbgload)
  );

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: four instances at LAT 0..3, directed stimulus with a
// scoreboard queue drained by a negedge monitor.
`timescale 1ns/1ps
module tb_ram_responder;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  ram_responder_if bus0 ();
  ram_responder_if bus1 ();
  ram_responder_if bus2 ();
  ram_responder_if bus3 ();

  logic  dbg_wen   [4];
  word_t dbg_addr  [4];
  word_t dbg_store [4];
  word_t dbg_load  [4];

  ram_responder #(.LAT(0), .DEPTH_BITS(8)) u_lat0 (
    .CLK(CLK), .nRST(nRST), .ram(bus0),
    .dbgWEN(dbg_wen[0]), .dbgaddr(dbg_addr[0]), .dbgstore(dbg_store[0]), .dbgload(dbg_load[0]));
  ram_responder #(.LAT(1), .DEPTH_BITS(8)) u_lat1 (
    .CLK(CLK), .nRST(nRST), .ram(bus1),
    .dbgWEN(dbg_wen[1]), .dbgaddr(dbg_addr[1]), .dbgstore(dbg_store[1]), .dbgload(dbg_load[1]));
  ram_responder #(.LAT(2), .DEPTH_BITS(8)) u_lat2 (
    .CLK(CLK), .nRST(nRST), .ram(bus2),
    .dbgWEN(dbg_wen[2]), .dbgaddr(dbg_addr[2]), .dbgstore(dbg_store[2]), .dbgload(dbg_load[2]));
  ram_responder #(.LAT(3), .DEPTH_BITS(8)) u_lat3 (
    .CLK(CLK), .nRST(nRST), .ram(bus3),
    .dbgWEN(dbg_wen[3]), .dbgaddr(dbg_addr[3]), .dbgstore(dbg_store[3]), .dbgload(dbg_load[3]));

  typedef struct {
    int        kind;   // 0: ramstate/ramload, 1: dbgload
    int        dut;
    ramstate_t st;
    word_t     val;
    string     name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic ramstate_t get_state(int d);
    case (d)
      0:       return bus0.ramstate;
      1:       return bus1.ramstate;
      2:       return bus2.ramstate;
      default: return bus3.ramstate;
    endcase
  endfunction

  function automatic word_t get_load(int d);
    case (d)
      0:       return bus0.ramload;
      1:       return bus1.ramload;
      2:       return bus2.ramload;
      default: return bus3.ramload;
    endcase
  endfunction

  task automatic drive(int d, logic ren, logic wen, word_t addr, word_t store);
    case (d)
      0: begin bus0.ramREN = ren; bus0.ramWEN = wen; bus0.ramaddr = addr; bus0.ramstore = store; end
      1: begin bus1.ramREN = ren; bus1.ramWEN = wen; bus1.ramaddr = addr; bus1.ramstore = store; end
      2: begin bus2.ramREN = ren; bus2.ramWEN = wen; bus2.ramaddr = addr; bus2.ramstore = store; end
      default: begin bus3.ramREN = ren; bus3.ramWEN = wen; bus3.ramaddr = addr; bus3.ramstore = store; end
    endcase
  endtask

  task automatic idle(int d);
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic exp_st(int d, ramstate_t st, word_t load, string name);
    exp_t e;
    e.kind = 0; e.dut = d; e.st = st; e.val = load; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic exp_dbg(int d, word_t addr, word_t val, string name);
    exp_t e;
    dbg_addr[d] = addr;
    e.kind = 1; e.dut = d; e.st = FREE; e.val = val; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic preload(int d, word_t addr, word_t val);
    dbg_wen[d]   = 1'b1;
    dbg_addr[d]  = addr;
    dbg_store[d] = val;
    tick();
    dbg_wen[d]   = 1'b0;
  endtask

  // Monitor: every falling edge, compare all expectations queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (e.kind == 0) begin
          if (get_state(e.dut) !== e.st || get_load(e.dut) !== e.val) begin
            errors++;
            $display("FAIL %s (LAT%0d): got state=%0d load=%h, expected state=%0d load=%h",
                     e.name, e.dut, get_state(e.dut), get_load(e.dut), e.st, e.val);
          end
        end else begin
          if (dbg_load[e.dut] !== e.val) begin
            errors++;
            $display("FAIL %s (LAT%0d): got dbgload=%h, expected %h",
                     e.name, e.dut, dbg_load[e.dut], e.val);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0;
    for (int d = 0; d < 4; d++) begin
      idle(d);
      dbg_wen[d] = 1'b0; dbg_addr[d] = 32'h0; dbg_store[d] = 32'h0;
    end
    tick();
    for (int d = 0; d < 4; d++) exp_st(d, FREE, 32'h0, "reset_free");
    tick();
    nRST = 1'b1;
    for (int d = 0; d < 4; d++) exp_st(d, FREE, 32'h0, "idle_free");
    tick();

    // LAT=2 read held: BUSY, BUSY, ACCESS, then a new transaction
    preload(2, 32'h40, 32'hDEADBEEF);
    drive(2, 1, 0, 32'h40, 32'h0); exp_st(2, BUSY,   32'h0,        "rd_c0"); tick();
    exp_st(2, BUSY,   32'h0,        "rd_c1"); tick();
    exp_st(2, ACCESS, 32'hDEADBEEF, "rd_c2"); tick();
    exp_st(2, BUSY,   32'h0,        "rd_c3_new"); tick();
    idle(2); exp_st(2, FREE, 32'h0, "rd_free"); tick();

    // LAT=2 write held three cycles
    drive(2, 0, 1, 32'h80, 32'h12345678); exp_st(2, BUSY, 32'h0, "wr_c0"); tick();
    exp_st(2, BUSY,   32'h0, "wr_c1"); tick();
    exp_st(2, ACCESS, 32'h0, "wr_c2"); tick();
    idle(2); exp_st(2, FREE, 32'h0, "wr_free"); exp_dbg(2, 32'h80, 32'h12345678, "wr_commit"); tick();

    // Write dropped mid-BUSY leaves memory untouched
    preload(2, 32'h88, 32'hAAAA5555);
    drive(2, 0, 1, 32'h88, 32'hCAFEF00D); exp_st(2, BUSY, 32'h0, "drop_c0"); tick();
    idle(2); exp_st(2, FREE, 32'h0, "drop_free"); tick();
    exp_dbg(2, 32'h88, 32'hAAAA5555, "drop_nowrite"); tick();

    // LAT=1 back-to-back two-word store; ramstore only matters in ACCESS
    drive(1, 0, 1, 32'h100, 32'hBAD0BAD0); exp_st(1, BUSY,   32'h0, "st2_c0"); tick();
    drive(1, 0, 1, 32'h100, 32'h11111111); exp_st(1, ACCESS, 32'h0, "st2_c1"); tick();
    drive(1, 0, 1, 32'h104, 32'hBAD0BAD0); exp_st(1, BUSY,   32'h0, "st2_c2"); tick();
    drive(1, 0, 1, 32'h104, 32'h22222222); exp_st(1, ACCESS, 32'h0, "st2_c3"); tick();
    idle(1); exp_st(1, FREE, 32'h0, "st2_free"); exp_dbg(1, 32'h100, 32'h11111111, "st2_w0"); tick();
    exp_dbg(1, 32'h104, 32'h22222222, "st2_w1"); tick();

    // Error conditions: no write, recovery once removed
    preload(2, 32'h0, 32'h0BADC0DE);
    drive(2, 1, 1, 32'h0, 32'hFFFFFFFF); exp_st(2, ERROR, 32'h0, "err_renwen"); tick();
    idle(2); exp_st(2, FREE, 32'h0, "err1_recover"); exp_dbg(2, 32'h0, 32'h0BADC0DE, "err1_nowrite"); tick();
    drive(2, 0, 1, 32'h42, 32'hFFFFFFFF); exp_st(2, ERROR, 32'h0, "err_misalign"); tick();
    idle(2); exp_st(2, FREE, 32'h0, "err2_recover"); exp_dbg(2, 32'h40, 32'hDEADBEEF, "err2_nowrite"); tick();
    drive(2, 0, 1, 32'h400, 32'hFFFFFFFF); exp_st(2, ERROR, 32'h0, "err_range"); tick();
    drive(2, 1, 0, 32'h40, 32'h0); exp_st(2, BUSY, 32'h0, "err3_recover");
    exp_dbg(2, 32'h0, 32'h0BADC0DE, "err3_nowrite"); tick();
    exp_st(2, BUSY,   32'h0,        "err3_c1"); tick();
    exp_st(2, ACCESS, 32'h0DEADBEEF, "err3_c2"); tick();
    idle(2); tick();

    // LAT=3 address change at cycle 1 restarts the count
    preload(3, 32'h44, 32'h44444444);
    drive(3, 1, 0, 32'h40, 32'h0); exp_st(3, BUSY, 32'h0, "chg_c0"); tick();
    drive(3, 1, 0, 32'h44, 32'h0); exp_st(3, BUSY, 32'h0, "chg_c1"); tick();
    exp_st(3, BUSY,   32'h0,        "chg_c2"); tick();
    exp_st(3, BUSY,   32'h0,        "chg_c3"); tick();
    exp_st(3, ACCESS, 32'h44444444, "chg_c4"); tick();
    idle(3); exp_st(3, FREE, 32'h0, "chg_free"); tick();

    // LAT=0: same-cycle ACCESS, and debug/controller write collisions
    preload(0, 32'h10, 32'h01020304);
    drive(0, 1, 0, 32'h10, 32'h0); exp_st(0, ACCESS, 32'h01020304, "lat0_rd"); tick();
    drive(0, 0, 1, 32'h24, 32'h00000001);
    dbg_wen[0] = 1'b1; dbg_addr[0] = 32'h28; dbg_store[0] = 32'h00000002;
    exp_st(0, ACCESS, 32'h0, "lat0_wr"); tick();
    dbg_wen[0] = 1'b0; idle(0);
    exp_st(0, FREE, 32'h0, "lat0_free"); exp_dbg(0, 32'h24, 32'h00000001, "coll_diff_ram"); tick();
    exp_dbg(0, 32'h28, 32'h00000002, "coll_diff_dbg"); tick();
    drive(0, 0, 1, 32'h30, 32'hAAAAAAAA);
    dbg_wen[0] = 1'b1; dbg_addr[0] = 32'h30; dbg_store[0] = 32'hBBBBBBBB;
    tick();
    dbg_wen[0] = 1'b0; idle(0);
    exp_dbg(0, 32'h30, 32'hAAAAAAAA, "coll_same"); tick();

    // Reset in cycle 1 of a LAT=2 write: FREE at once, write lost
    preload(2, 32'hC0, 32'h5A5A5A5A);
    drive(2, 0, 1, 32'hC0, 32'hFFFF0000); exp_st(2, BUSY, 32'h0, "rst_c0"); tick();
    exp_st(2, BUSY, 32'h0, "rst_c1");
    @(negedge CLK); #1;
    nRST = 1'b0;
    exp_st(2, FREE, 32'h0, "rst_free");
    tick();
    exp_st(2, FREE, 32'h0, "rst_hold"); tick();
    idle(2); nRST = 1'b1;
    exp_st(2, FREE, 32'h0, "rst_release"); exp_dbg(2, 32'hC0, 32'h5A5A5A5A, "rst_nowrite"); tick();
    tick();

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
